// File: rtl/handle_mem_issue_pkg.sv
// rtl/handle_mem_issue_pkg.sv - shared widths, op codes and request layout for the handle path
package handle_mem_issue_pkg;

   localparam int ADDR_WIDTH = 64;
   localparam int HNDL_WIDTH = 16;
   localparam int DATA_WIDTH = 64;
   localparam int OP_WIDTH   = 3;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_NOP   = 3'd0,
      OP_READ  = 3'd1,
      OP_WRITE = 3'd2
   } mem_op_e;

   typedef struct packed {
      logic [OP_WIDTH-1:0]   op;
      logic [ADDR_WIDTH-1:0] address;
      logic [DATA_WIDTH-1:0] data;
   } mem_req_t;

   localparam int REQ_WIDTH = $bits(mem_req_t);

   function automatic logic op_is_access(input logic [OP_WIDTH-1:0] op);
      return (op == OP_READ) || (op == OP_WRITE);
   endfunction

   function automatic logic op_is_illegal(input logic [OP_WIDTH-1:0] op);
      return op > OP_WRITE;
   endfunction

endpackage

// File: rtl/handle_req_fifo.sv
// rtl/handle_req_fifo.sv - request FIFO holding op+address+data entries
module handle_req_fifo
   import handle_mem_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_push,
   input  logic [REQ_WIDTH-1:0] i_req,
   input  logic                 i_pop,
   output logic [REQ_WIDTH-1:0] o_head,
   output logic                 o_full,
   output logic                 o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [REQ_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 do_push;
   logic                 do_pop;

   assign o_full  = (count == CW'(DEPTH));
   assign o_empty = (count == '0);
   assign o_head  = mem[rd_ptr];
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge i_clock) begin
      if (!i_reset && do_push) begin
         mem[wr_ptr] <= i_req;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/handle_mem_issue.sv
// rtl/handle_mem_issue.sv - queues translated requests, gates issue on outstanding reads, returns read data
module handle_mem_issue
   import handle_mem_issue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int MAX_RD = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [OP_WIDTH-1:0]   i_op,
   input  logic [ADDR_WIDTH-1:0] i_address,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_ready,
   output logic                  o_mem_valid,
   input  logic                  i_mem_ready,
   output logic [OP_WIDTH-1:0]   o_mem_op,
   output logic [ADDR_WIDTH-1:0] o_mem_address,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   input  logic                  i_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_rsp_data,
   output logic                  o_rd_valid,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [2:0]            o_outstanding,
   output logic                  o_error
);

   logic [REQ_WIDTH-1:0] head_bits;
   mem_req_t             head;
   mem_req_t             in_req;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 issue;
   logic                 rd_stall;
   logic                 rd_issue;
   logic                 rsp;
   logic                 rsp_orphan;
   logic                 rsp_take;

   assign in_req = '{op: i_op, address: i_address, data: i_data};
   assign head   = head_bits;

   assign o_ready = !full;
   assign push    = !i_reset && o_ready && op_is_access(i_op);

   assign rd_stall    = (head.op == OP_READ) && (o_outstanding == 3'(MAX_RD));
   assign o_mem_valid = !empty && !rd_stall;
   assign issue       = !i_reset && o_mem_valid && i_mem_ready;
   assign rd_issue    = issue && (head.op == OP_READ);

   // A response with nothing outstanding (and no read leaving this cycle) is an orphan.
   assign rsp        = !i_reset && i_rsp_valid;
   assign rsp_orphan = rsp && (o_outstanding == 3'd0) && !rd_issue;
   assign rsp_take   = rsp && !rsp_orphan;

   assign o_mem_op      = o_mem_valid ? head.op      : OP_NOP;
   assign o_mem_address = o_mem_valid ? head.address : '0;
   assign o_mem_data    = o_mem_valid ? head.data    : '0;

   handle_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (push),
      .i_req   (in_req),
      .i_pop   (issue),
      .o_head  (head_bits),
      .o_full  (full),
      .o_empty (empty)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_outstanding <= 3'd0;
         o_error       <= 1'b0;
         o_rd_valid    <= 1'b0;
         o_rd_data     <= '0;
      end else begin
         case ({rd_issue, rsp_take})
            2'b10:   o_outstanding <= o_outstanding + 3'd1;
            2'b01:   o_outstanding <= o_outstanding - 3'd1;
            default: o_outstanding <= o_outstanding;
         endcase
         o_error    <= o_error | rsp_orphan | op_is_illegal(i_op);
         o_rd_valid <= rsp_take;
         if (rsp_take) o_rd_data <= i_rsp_data;
      end
   end

endmodule

// File: tb/tb_handle_mem_issue.sv
// tb/tb_handle_mem_issue.sv - directed self-checking bench for handle_mem_issue
module tb_handle_mem_issue;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic [2:0]  i_op;
   logic [63:0] i_address;
   logic [63:0] i_data;
   logic        o_ready;
   logic        o_mem_valid;
   logic        i_mem_ready;
   logic [2:0]  o_mem_op;
   logic [63:0] o_mem_address;
   logic [63:0] o_mem_data;
   logic        i_rsp_valid;
   logic [63:0] i_rsp_data;
   logic        o_rd_valid;
   logic [63:0] o_rd_data;
   logic [2:0]  o_outstanding;
   logic        o_error;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 i_clock = ~i_clock;

   handle_mem_issue #(.DEPTH(4), .MAX_RD(2)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_op          (i_op),
      .i_address     (i_address),
      .i_data        (i_data),
      .o_ready       (o_ready),
      .o_mem_valid   (o_mem_valid),
      .i_mem_ready   (i_mem_ready),
      .o_mem_op      (o_mem_op),
      .o_mem_address (o_mem_address),
      .o_mem_data    (o_mem_data),
      .i_rsp_valid   (i_rsp_valid),
      .i_rsp_data    (i_rsp_data),
      .o_rd_valid    (o_rd_valid),
      .o_rd_data     (o_rd_data),
      .o_outstanding (o_outstanding),
      .o_error       (o_error)
   );

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the falling edge.
   task automatic tick();
      @(negedge i_clock);
      #1;
   endtask

   initial begin
      i_reset = 1'b1; i_op = 3'd0; i_address = '0; i_data = '0;
      i_mem_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_data = '0;
      tick(); tick();
      check_vec("rst_ready", 64'(o_ready), 64'd1);
      check_vec("rst_mem_valid", 64'(o_mem_valid), 64'd0);
      check_vec("rst_mem_op", 64'(o_mem_op), 64'd0);
      check_vec("rst_mem_addr", o_mem_address, 64'd0);
      check_vec("rst_mem_data", o_mem_data, 64'd0);
      check_vec("rst_rd_valid", 64'(o_rd_valid), 64'd0);
      check_vec("rst_rd_data", o_rd_data, 64'd0);
      check_vec("rst_outstanding", 64'(o_outstanding), 64'd0);
      check_vec("rst_error", 64'(o_error), 64'd0);
      i_reset = 1'b0;

      // single WRITE with memory ready
      i_op = 3'd2; i_address = 64'h10; i_data = 64'd8; i_mem_ready = 1'b1;
      check_vec("wr_no_bypass", 64'(o_mem_valid), 64'd0);
      tick();
      i_op = 3'd0;
      check_vec("wr_valid", 64'(o_mem_valid), 64'd1);
      check_vec("wr_op", 64'(o_mem_op), 64'd2);
      check_vec("wr_addr", o_mem_address, 64'h10);
      check_vec("wr_data", o_mem_data, 64'd8);
      tick();
      check_vec("wr_popped", 64'(o_mem_valid), 64'd0);
      check_vec("wr_outstanding", 64'(o_outstanding), 64'd0);

      // five READs into a depth-4 FIFO with memory stalled
      i_mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         i_op = 3'd1; i_address = 64'h100 + 64'(i); i_data = 64'd0;
         check_vec("fill_ready", 64'(o_ready), (i < 4) ? 64'd1 : 64'd0);
         tick();
      end
      i_op = 3'd0;
      check_vec("full_ready", 64'(o_ready), 64'd0);
      check_vec("full_head_valid", 64'(o_mem_valid), 64'd1);
      check_vec("full_head_addr", o_mem_address, 64'h100);
      tick();
      check_vec("hold_head_addr", o_mem_address, 64'h100);
      check_vec("hold_head_op", 64'(o_mem_op), 64'd1);

      // drain with MAX_RD=2 and no responses
      i_mem_ready = 1'b1;
      tick();
      check_vec("rd1_outstanding", 64'(o_outstanding), 64'd1);
      check_vec("rd1_next_addr", o_mem_address, 64'h101);
      tick();
      check_vec("rd2_outstanding", 64'(o_outstanding), 64'd2);
      check_vec("stall_valid", 64'(o_mem_valid), 64'd0);
      check_vec("stall_op", 64'(o_mem_op), 64'd0);
      check_vec("stall_ready", 64'(o_ready), 64'd1);
      tick();
      check_vec("stall_hold_out", 64'(o_outstanding), 64'd2);

      i_rsp_valid = 1'b1; i_rsp_data = 64'hAB;
      tick();
      i_rsp_valid = 1'b0;
      check_vec("rsp_rd_valid", 64'(o_rd_valid), 64'd1);
      check_vec("rsp_rd_data", o_rd_data, 64'hAB);
      check_vec("rsp_outstanding", 64'(o_outstanding), 64'd1);
      check_vec("rd3_valid", 64'(o_mem_valid), 64'd1);
      check_vec("rd3_addr", o_mem_address, 64'h102);

      // READ issue and response together at outstanding=1
      i_rsp_valid = 1'b1; i_rsp_data = 64'hCD;
      tick();
      i_rsp_valid = 1'b0;
      check_vec("both_outstanding", 64'(o_outstanding), 64'd1);
      check_vec("both_rd_data", o_rd_data, 64'hCD);
      check_vec("rd4_addr", o_mem_address, 64'h103);
      tick();
      check_vec("rd4_outstanding", 64'(o_outstanding), 64'd2);

      i_mem_ready = 1'b0; i_rsp_valid = 1'b1; i_rsp_data = 64'hEE;
      tick();
      tick();
      i_rsp_valid = 1'b0;
      tick();
      check_vec("drain_rd_valid", 64'(o_rd_valid), 64'd0);
      check_vec("drain_rd_hold", o_rd_data, 64'hEE);
      check_vec("drain_outstanding", 64'(o_outstanding), 64'd0);
      check_vec("fifth_not_pushed", 64'(o_mem_valid), 64'd0);
      check_vec("drain_error", 64'(o_error), 64'd0);

      // orphan response
      i_rsp_valid = 1'b1; i_rsp_data = 64'h55;
      tick();
      i_rsp_valid = 1'b0;
      check_vec("orphan_error", 64'(o_error), 64'd1);
      check_vec("orphan_outstanding", 64'(o_outstanding), 64'd0);
      tick();
      check_vec("error_sticky", 64'(o_error), 64'd1);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      check_vec("error_cleared", 64'(o_error), 64'd0);

      // illegal op
      i_op = 3'd5; i_address = 64'h77;
      tick();
      i_op = 3'd0;
      check_vec("illegal_error", 64'(o_error), 64'd1);
      check_vec("illegal_not_pushed", 64'(o_mem_valid), 64'd0);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;

      // reset with a read in flight and two queued writes
      i_op = 3'd1; i_address = 64'h200; i_mem_ready = 1'b1;
      tick();
      i_op = 3'd0;
      tick();
      check_vec("inflight_outstanding", 64'(o_outstanding), 64'd1);
      i_mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         i_op = 3'd2; i_address = 64'h300 + 64'(i); i_data = 64'(i);
         tick();
      end
      i_op = 3'd0;
      check_vec("queued_valid", 64'(o_mem_valid), 64'd1);
      check_vec("queued_addr", o_mem_address, 64'h300);
      i_reset = 1'b1; i_op = 3'd2; i_rsp_valid = 1'b1; i_rsp_data = 64'h99;
      tick();
      i_reset = 1'b0; i_op = 3'd0; i_rsp_valid = 1'b0;
      check_vec("post_rst_valid", 64'(o_mem_valid), 64'd0);
      check_vec("post_rst_ready", 64'(o_ready), 64'd1);
      check_vec("post_rst_outstanding", 64'(o_outstanding), 64'd0);
      check_vec("post_rst_rd_valid", 64'(o_rd_valid), 64'd0);
      check_vec("post_rst_error", 64'(o_error), 64'd0);
      i_rsp_valid = 1'b1; i_rsp_data = 64'h42;
      tick();
      i_rsp_valid = 1'b0;
      check_vec("late_rsp_error", 64'(o_error), 64'd1);
      check_vec("late_rsp_outstanding", 64'(o_outstanding), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/handle_mem_issue.md
HANDLE_MEM_ISSUE -- requirements
Module: handle_mem_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: request FIFO entries; power of two, 2..16.
REQ-002 The block SHALL have parameter MAX_RD, default 4: maximum outstanding reads, 1..7.
REQ-003 The block SHALL have port i_clock, input, 1: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port i_op, input, 3: translated op from the handle translation stage; 0=NOP, 1=READ, 2=WRITE.
REQ-006 The block SHALL have port i_address, input, ADDR_WIDTH (64): translated physical address.
REQ-007 The block SHALL have port i_data, input, 64: write data.
REQ-008 The block SHALL have port o_ready, output, 1: FIFO can accept this cycle.
REQ-009 The block SHALL have port o_mem_valid, output, 1: request presented to memory.
REQ-010 The block SHALL have port i_mem_ready, input, 1: memory accepts the request.
REQ-011 The block SHALL have ports o_mem_op (output, 3), o_mem_address (output, 64) and o_mem_data (output, 64): the head request.
REQ-012 The block SHALL have ports i_rsp_valid (input, 1) and i_rsp_data (input, 64): in-order read response from memory.
REQ-013 The block SHALL have ports o_rd_valid (output, 1) and o_rd_data (output, 64): read data returned to the core.
REQ-014 The block SHALL have port o_outstanding, output, 3: count of issued, unanswered reads.
REQ-015 The block SHALL have port o_error, output, 1: sticky protocol error flag.

Function
REQ-016 Accept: a push SHALL occur when o_ready=1 and i_op is READ or WRITE; NOP SHALL be ignored.
REQ-017 An i_op value of 3..7 SHALL NOT be pushed and SHALL set o_error.
REQ-018 o_ready SHALL be 1 exactly when FIFO count < DEPTH, from registered state only; no same-cycle bypass when full.
REQ-019 Latency: an entry pushed at edge N SHALL appear on o_mem_* with o_mem_valid=1 from cycle N+1 when the FIFO was empty.
REQ-020 o_mem_valid SHALL be 1 when FIFO non-empty, except when the head is READ and o_outstanding=MAX_RD (read stall).
REQ-021 Issue: the head SHALL pop on o_mem_valid & i_mem_ready; o_mem_* SHALL be held stable while o_mem_valid=1 and i_mem_ready=0.
REQ-022 When o_mem_valid=0, o_mem_op SHALL read NOP (0).
REQ-023 Push and pop in the same cycle SHALL leave the count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-024 o_outstanding SHALL increment on READ issue and decrement on i_rsp_valid, and SHALL be unchanged when both occur in the same cycle.
REQ-025 An i_rsp_valid received while o_outstanding=0 and no same-cycle READ issue SHALL be dropped, SHALL set o_error, and SHALL leave the counter at 0.
REQ-026 o_rd_valid and o_rd_data SHALL be registered copies of i_rsp_valid and i_rsp_data (1-cycle latency); o_rd_data SHALL hold its value when o_rd_valid=0.
REQ-027 WRITE requests SHALL NOT affect o_outstanding.
REQ-028 o_error SHALL clear only on reset.

Reset
REQ-029 On i_reset=1 the block SHALL empty the FIFO and zero the pointers and o_outstanding, and SHALL drive o_mem_valid=0, o_mem_op=0, o_mem_address=0, o_mem_data=0, o_rd_valid=0, o_rd_data=0, o_error=0, and o_ready=1 in the following cycle.
REQ-030 A reset asserted mid-handshake SHALL discard queued and in-flight requests; responses to pre-reset reads arriving after reset SHALL flag o_error.
REQ-031 While i_reset=1, pushes and responses SHALL be ignored.

Structure
REQ-032 ADDR_WIDTH, HNDL_WIDTH and the op codes NOP/READ/WRITE SHALL reside in a shared package/header used by all handle-path blocks.
REQ-033 The FIFO storage SHALL be a sub-module named handle_req_fifo (op+address+data entry, push/pop/full/empty); issue gating and counters SHALL stay in the top module.

Verification
REQ-034 Scenario: WRITE addr 0x10, data 8, with i_mem_ready=1 -> o_mem_valid=1 next cycle with op 2, addr 0x10, data 8; popped; o_outstanding stays 0.
REQ-035 Scenario: 5 READs pushed with i_mem_ready=0, DEPTH=4 -> o_ready=0 after the 4th push; the 5th is not accepted; head held stable.
REQ-036 Scenario: MAX_RD=2, 3 READs, ready=1, no responses -> 2 issued, o_outstanding=2, o_mem_valid=0; one i_rsp_valid (data 0xAB) -> o_rd_valid with 0xAB next cycle, 3rd READ issues.
REQ-037 Scenario: READ issue and i_rsp_valid in the same cycle at o_outstanding=1 -> stays 1.
REQ-038 Scenario: i_rsp_valid at o_outstanding=0, then i_op=5 -> o_error=1, counter 0, nothing pushed; i_reset -> o_error=0.
REQ-039 Scenario: 2 queued entries, i_reset for 1 cycle -> next cycle o_mem_valid=0, o_ready=1, o_outstanding=0.
